// File: rtl/conv_xif_scheduler_pkg.sv
// Shared types for the X-interface convolution scheduler: slot bookkeeping and result records.
package conv_xif_pkg;

  localparam int unsigned XIF_XLEN = 32;
  localparam int unsigned XIF_ID_W = 4;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2,
    KILLED    = 2'd3
  } slot_state_e;

  typedef struct packed {
    slot_state_e           state;
    logic [XIF_ID_W-1:0]   id;
    logic [4:0]            rd;
    logic                  sgn;
    logic [XIF_XLEN-1:0]   op_a;
    logic [XIF_XLEN-1:0]   op_b;
  } slot_t;

  typedef struct packed {
    logic [XIF_ID_W-1:0]   id;
    logic [4:0]            rd;
    logic [XIF_XLEN-1:0]   data;
  } res_t;

endpackage

// File: rtl/conv_xif_scheduler_if.sv
// Issue/commit/result channels between the core and the convolution scheduler.
interface conv_xif_scheduler_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ID_W = 4
);
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic            issue_accept_i;
  logic [ID_W-1:0] issue_id_i;
  logic [4:0]      issue_rd_i;
  logic            issue_signed_i;
  logic [XLEN-1:0] issue_op_a_i;
  logic [XLEN-1:0] issue_op_b_i;
  logic            commit_valid_i;
  logic [ID_W-1:0] commit_id_i;
  logic            commit_kill_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [ID_W-1:0] result_id_o;
  logic [4:0]      result_rd_o;
  logic [XLEN-1:0] result_data_o;
  logic            result_we_o;
  logic            busy_o;

  modport slave (
    input  issue_valid_i, issue_accept_i, issue_id_i, issue_rd_i, issue_signed_i,
    input  issue_op_a_i, issue_op_b_i, commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output issue_ready_o, result_valid_o, result_id_o, result_rd_o, result_data_o,
    output result_we_o, busy_o
  );

  modport master (
    output issue_valid_i, issue_accept_i, issue_id_i, issue_rd_i, issue_signed_i,
    output issue_op_a_i, issue_op_b_i, commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  issue_ready_o, result_valid_o, result_id_o, result_rd_o, result_data_o,
    input  result_we_o, busy_o
  );
endinterface

// File: rtl/conv_xif_scheduler_dot_pe.sv
// Packed-element dot product: per-lane multiply, summation, then a PE_LAT-deep pipeline
// carrying the valid bit and id/rd alongside the data.
module conv_dot_pe import conv_xif_pkg::*; #(
  parameter int unsigned XLEN   = XIF_XLEN,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned PE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                sgn,
  input  logic [XLEN-1:0]     op_a,
  input  logic [XLEN-1:0]     op_b,
  input  logic [XIF_ID_W-1:0] in_id,
  input  logic [4:0]          in_rd,
  output logic                out_valid,
  output res_t                out_res
);
  localparam int unsigned LANES = XLEN / ELEM_W;

  function automatic logic [XLEN-1:0] ext(input logic [ELEM_W-1:0] e, input logic s);
    return {{(XLEN-ELEM_W){s & e[ELEM_W-1]}}, e};
  endfunction

  logic [XLEN-1:0] sum;
  logic            vld  [PE_LAT];
  res_t            pipe [PE_LAT];

  // Extending to XLEN before multiplying makes the truncated product exact modulo 2^XLEN.
  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum = sum + ext(op_a[k*ELEM_W +: ELEM_W], sgn) * ext(op_b[k*ELEM_W +: ELEM_W], sgn);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PE_LAT; i++) begin
        vld[i]  <= 1'b0;
        pipe[i] <= '0;
      end
    end else begin
      vld[0]  <= in_valid;
      pipe[0] <= '{id: in_id, rd: in_rd, data: sum};
      for (int unsigned i = 1; i < PE_LAT; i++) begin
        vld[i]  <= vld[i-1];
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_valid = vld[PE_LAT-1];
  assign out_res   = pipe[PE_LAT-1];

endmodule

// File: rtl/conv_xif_scheduler.sv
// In-order convolution scheduler: holds issued instructions until commit, dispatches them to
// the dot-product PE under credit control, and returns results through a backpressured FIFO.
module conv_xif_scheduler import conv_xif_pkg::*; #(
  parameter int unsigned XLEN   = XIF_XLEN,
  parameter int unsigned ID_W   = XIF_ID_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned PE_LAT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  conv_xif_scheduler_if.slave   xif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  slot_t            slots   [DEPTH];
  slot_t            slots_d [DEPTH];
  slot_t            new_slot;
  slot_t            head_slot;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] slot_cnt, credits;
  res_t             fifo [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [ID_W-1:0]  commit_id;
  logic             alloc, dispatch, pop_head, res_pop;
  logic             pe_valid;
  res_t             pe_res;

  assign commit_id         = xif.commit_id_i;
  assign xif.issue_ready_o = !rst_i && (slot_cnt < CNT_W'(DEPTH));
  assign alloc             = xif.issue_valid_i & xif.issue_ready_o & xif.issue_accept_i;
  assign head_slot         = slots[head];
  assign dispatch          = (head_slot.state == COMMITTED) && (credits != '0);
  assign pop_head          = dispatch || (head_slot.state == KILLED);
  assign res_pop           = xif.result_valid_o & xif.result_ready_i;

  // A commit naming the id being issued this cycle lands directly in the new slot.
  always_comb begin
    new_slot       = '0;
    new_slot.state = ISSUED;
    new_slot.id    = xif.issue_id_i;
    new_slot.rd    = xif.issue_rd_i;
    new_slot.sgn   = xif.issue_signed_i;
    new_slot.op_a  = xif.issue_op_a_i;
    new_slot.op_b  = xif.issue_op_b_i;
    if (xif.commit_valid_i && (commit_id == xif.issue_id_i)) begin
      new_slot.state = xif.commit_kill_i ? KILLED : COMMITTED;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slots_d[i] = slots[i];
      if (xif.commit_valid_i && (slots[i].state == ISSUED) && (slots[i].id == commit_id)) begin
        slots_d[i].state = xif.commit_kill_i ? KILLED : COMMITTED;
      end
    end
    if (pop_head) slots_d[head].state = FREE;
    if (alloc)    slots_d[tail] = new_slot;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
      head     <= '0;
      tail     <= '0;
      slot_cnt <= '0;
      credits  <= CNT_W'(DEPTH);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      slots <= slots_d;
      if (pop_head) head <= head + PTR_W'(1);
      if (alloc)    tail <= tail + PTR_W'(1);
      if (alloc && !pop_head)      slot_cnt <= slot_cnt + CNT_W'(1);
      else if (!alloc && pop_head) slot_cnt <= slot_cnt - CNT_W'(1);
      if (dispatch && !res_pop)      credits <= credits - CNT_W'(1);
      else if (!dispatch && res_pop) credits <= credits + CNT_W'(1);
      if (pe_valid) wr_ptr <= wr_ptr + PTR_W'(1);
      if (res_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (pe_valid && !res_pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!pe_valid && res_pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (pe_valid) fifo[wr_ptr] <= pe_res;
  end

  conv_dot_pe #(.XLEN(XLEN), .ELEM_W(ELEM_W), .PE_LAT(PE_LAT)) u_pe (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (dispatch),
    .sgn       (head_slot.sgn),
    .op_a      (head_slot.op_a),
    .op_b      (head_slot.op_b),
    .in_id     (head_slot.id),
    .in_rd     (head_slot.rd),
    .out_valid (pe_valid),
    .out_res   (pe_res)
  );

  // Outstanding credits cover everything in the PE and result FIFO.
  assign xif.result_valid_o = !rst_i && (fifo_cnt != '0);
  assign xif.result_we_o    = xif.result_valid_o;
  assign xif.result_id_o    = fifo[rd_ptr].id;
  assign xif.result_rd_o    = fifo[rd_ptr].rd;
  assign xif.result_data_o  = fifo[rd_ptr].data;
  assign xif.busy_o         = !rst_i && ((slot_cnt != '0) || (credits != CNT_W'(DEPTH)));

endmodule
